// File: rtl/tap_result_pkg.sv
// Shared types and constants for the tap result collector.
// Provides byte width, sync byte, FSM state enums and a clog2 helper.
package tap_result_pkg;

  localparam int BYTE_W = 8;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    C_WAIT,
    C_PULSE,
    C_CLEAR
  } cap_state_t;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((int'(1) << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tap_result_fifo.sv
// Result FIFO: synchronous write, registered storage, DEPTH entries of W bits.
// Ports: clk/rst, push+wr_data, pop, rd_data (head), next_data/next_valid
// (entry that becomes head after a pop), full, empty, count.
module tap_result_fifo
  import tap_result_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wr_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic [W-1:0]               next_data,
  output logic                       next_valid,
  output logic                       full,
  output logic                       empty,
  output logic [clog2(DEPTH+1)-1:0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr + AW'(1);
  assign rd_data = mem[rd_ptr];

  // With a single stored entry, the entry following the head is the one
  // being written this cycle (if any).
  assign next_valid = (count > CW'(1)) || (do_push && count == CW'(1));
  assign next_data  = (count > CW'(1)) ? mem[rd_nxt] : wr_data;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tap_result_collector.sv
// Captures engine tap sets into a FIFO, pulses ext_res, streams bytes out.
// Ports: clk, res, found, started, co_buf, ext_res, out_* (valid/ready), pending.
// Macro RESULT_HEADER_EN: prefix each frame with 0xA5 and a sequence byte.
module tap_result_collector
  import tap_result_pkg::*;
#(
  parameter int NUM_OF_TAPS = 16,
  parameter int SIZE        = 32,
  parameter int DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          found,
  input  logic                          started,
  input  logic [NUM_OF_TAPS*8-1:0]      co_buf,
  output logic                          ext_res,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [clog2(DEPTH+1)-1:0]     pending
);

  localparam int TAP_W = NUM_OF_TAPS * BYTE_W;
`ifdef RESULT_HEADER_EN
  localparam int HDR = 2;
  localparam int EW  = TAP_W + BYTE_W;
`else
  localparam int HDR = 0;
  localparam int EW  = TAP_W;
`endif
  localparam int LEN = NUM_OF_TAPS + HDR;
  localparam int PW  = clog2(LEN + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SIZE < 1) begin : g_bad_cfg
    $error("tap_result_collector: bad DEPTH or SIZE");
  end

  cap_state_t    cstate;
  ser_state_t    sstate;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          next_valid;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_data;
  logic [EW-1:0] next_data;
  logic [EW-1:0] frame;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_nxt;
  logic          hs;
  logic          at_last;

`ifdef RESULT_HEADER_EN
  logic [7:0] seq;

  assign wr_entry = {seq, co_buf};

  always_ff @(posedge clk or posedge res) begin
    if (res)       seq <= '0;
    else if (push) seq <= seq + 8'd1;
  end
`else
  assign wr_entry = co_buf;
`endif

  // Full is taken from registered occupancy, so a pop in the same
  // cycle never frees room for a capture until the next cycle.
  assign push    = (cstate == C_WAIT) && found && started && !full;
  assign hs      = out_valid && out_ready;
  assign at_last = pos == PW'(LEN - 1);
  assign pop     = hs && at_last;
  assign pos_nxt = pos + PW'(1);

  function automatic logic [7:0] byte_at(
    input logic [EW-1:0] e,
    input logic [PW-1:0] p
  );
    logic [EW-1:0] sh;
    sh = '0;
`ifdef RESULT_HEADER_EN
    if (p == '0)     return SYNC_BYTE;
    if (p == PW'(1)) return e[EW-1 -: BYTE_W];
    sh = e >> (BYTE_W * (int'(p) - 2));
`else
    sh = e >> (BYTE_W * int'(p));
`endif
    return sh[BYTE_W-1:0];
  endfunction

  tap_result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (res),
    .push       (push),
    .wr_data    (wr_entry),
    .pop        (pop),
    .rd_data    (rd_data),
    .next_data  (next_data),
    .next_valid (next_valid),
    .full       (full),
    .empty      (empty),
    .count      (pending)
  );

  // Capture: one restart pulse per stored result; C_CLEAR waits for
  // found to drop so a held flag is not captured twice.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cstate  <= C_WAIT;
      ext_res <= 1'b0;
    end else begin
      unique case (cstate)
        C_WAIT: begin
          ext_res <= 1'b0;
          if (push) cstate <= C_PULSE;
        end
        C_PULSE: begin
          ext_res <= 1'b1;
          cstate  <= C_CLEAR;
        end
        C_CLEAR: begin
          ext_res <= 1'b0;
          if (!found) cstate <= C_WAIT;
        end
        default: begin
          ext_res <= 1'b0;
          cstate  <= C_WAIT;
        end
      endcase
    end
  end

  // Serializer: outputs are registered and only move on a handshake.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sstate    <= S_IDLE;
      frame     <= '0;
      pos       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (sstate)
        S_IDLE: begin
          if (!empty) begin
            frame     <= rd_data;
            pos       <= '0;
            out_data  <= byte_at(rd_data, '0);
            out_valid <= 1'b1;
            out_last  <= 1'(LEN == 1);
            sstate    <= S_SEND;
          end
        end
        S_SEND: begin
          if (hs) begin
            if (!at_last) begin
              pos      <= pos_nxt;
              out_data <= byte_at(frame, pos_nxt);
              out_last <= pos_nxt == PW'(LEN - 1);
            end else if (next_valid) begin
              frame    <= next_data;
              pos      <= '0;
              out_data <= byte_at(next_data, '0);
              out_last <= 1'(LEN == 1);
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              sstate    <= S_IDLE;
            end
          end
        end
        default: sstate <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_result_collector.sv
// Scoreboard bench for tap_result_collector: random tap sets, queue model.
// Optional RESULT_HEADER_EN adds sync/sequence bytes to the expected frames.
module tb_tap_result_collector;

  localparam int NT    = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            res;
  logic            found;
  logic            started;
  logic [NT*8-1:0] co_buf;
  logic            ext_res;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [2:0]      pending;

  always #5 clk = ~clk;

  tap_result_collector #(
    .NUM_OF_TAPS (NT),
    .SIZE        (32),
    .DEPTH       (DEPTH)
  ) dut (
    .clk       (clk),
    .res       (res),
    .found     (found),
    .started   (started),
    .co_buf    (co_buf),
    .ext_res   (ext_res),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .pending   (pending)
  );

  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp_q[$];
  int         pulses = 0;
  int         hs_count = 0;
  int         ready_mode = 0;
  logic       ready_val = 1'b1;
`ifdef RESULT_HEADER_EN
  int         seqn = 0;
`endif

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference frame: [A5, seq] then tap bytes 0..NT-1, last on final tap.
  task automatic push_result(input logic [NT*8-1:0] d);
`ifdef RESULT_HEADER_EN
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'(seqn)});
    seqn = (seqn + 1) % 256;
`endif
    for (int i = 0; i < NT; i++)
      exp_q.push_back({1'(i == NT - 1), d[8*i +: 8]});
  endtask

  function automatic logic [NT*8-1:0] rand_buf();
    logic [NT*8-1:0] r;
    for (int i = 0; i < NT / 4; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = ready_val;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic       stall_prev = 1'b0;
  logic       ext_prev = 1'b0;
  logic [8:0] held;
  logic [8:0] e;

  always @(negedge clk) begin
    if (res) begin
      stall_prev = 1'b0;
      ext_prev   = 1'b0;
    end else begin
      if (stall_prev)
        check("hold", {out_valid, out_last, out_data}, {1'b1, held});
      if (ext_res) begin
        pulses++;
        check("ext_res_width", 32'(ext_prev), 0);
      end
      ext_prev = ext_res;
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_byte actual=%0h expected=none",
                   {out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          check("byte", {out_last, out_data}, e);
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_last, out_data};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input int budget);
    int p0;
    p0 = pulses;
    for (int i = 0; i < budget && pulses == p0; i++) @(negedge clk);
    #1;
    check("ext_res_seen", 32'(pulses != p0), 1);
  endtask

  task automatic issue(input logic [NT*8-1:0] d);
    co_buf = d;
    found  = 1'b1;
    push_result(d);
    wait_pulse(200);
    tick(1);
    found  = 1'b0;
    co_buf = rand_buf();
    tick(2);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    tick(2);
    check("idle_valid", 32'(out_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  logic [NT*8-1:0] d;
  int              p0;
  int              h0;

  initial begin
    res     = 1'b1;
    found   = 1'b0;
    started = 1'b0;
    co_buf  = '0;
    tick(2);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ext_res", 32'(ext_res), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_pending", 32'(pending), 0);
    res = 1'b0;
    tick(1);

    // single result with known pattern, found held 10 cycles
    started = 1'b1;
    for (int i = 0; i < NT; i++) d[8*i +: 8] = 8'(i);
    co_buf = d;
    found  = 1'b1;
    push_result(d);
    p0 = pulses;
    @(negedge clk);
    check("ext_res_c0", 32'(ext_res), 0);
    @(negedge clk);
    check("ext_res_c1", 32'(ext_res), 0);
    check("pending_c1", 32'(pending), 1);
    @(negedge clk);
    check("ext_res_c2", 32'(ext_res), 1);
    check("valid_c2", 32'(out_valid), 1);
    check("data_c2", 32'(out_data), 0);
    tick(8);
    found = 1'b0;
    drain(100);
    check("single_pulses", pulses - p0, 1);
    check("single_pending", 32'(pending), 0);

    // backpressure: ready toggles every cycle
    ready_mode = 1;
    p0 = pulses;
    for (int k = 0; k < 3; k++) issue(rand_buf());
    drain(400);
    check("bp_pulses", pulses - p0, 3);
    ready_mode = 0;
    ready_val  = 1'b1;
    tick(2);

    // FIFO full: fifth result must wait for a pop
    ready_val = 1'b0;
    tick(1);
    p0 = pulses;
    for (int k = 0; k < DEPTH; k++) issue(rand_buf());
    check("full_pending", 32'(pending), DEPTH);
    check("full_pulses", pulses - p0, DEPTH);
    d      = rand_buf();
    co_buf = d;
    found  = 1'b1;
    push_result(d);
    tick(12);
    check("fifth_blocked", pulses - p0, DEPTH);
    check("fifth_pending", 32'(pending), DEPTH);
    ready_val = 1'b1;
    wait_pulse(100);
    tick(1);
    found = 1'b0;
    tick(2);
    drain(500);
    check("full_pulses_all", pulses - p0, DEPTH + 1);
    check("full_pending_end", 32'(pending), 0);

    // qualifier: no capture while started is low
    started = 1'b0;
    p0      = pulses;
    d       = rand_buf();
    co_buf  = d;
    found   = 1'b1;
    tick(6);
    check("qual_pulses", pulses - p0, 0);
    check("qual_pending", 32'(pending), 0);
    started = 1'b1;
    push_result(d);
    tick(1);
    check("qual_capture", 32'(pending), 1);
    wait_pulse(50);
    tick(1);
    found = 1'b0;
    tick(2);
    drain(200);

    // reset in the middle of a frame
    ready_mode = 2;
    h0 = hs_count;
    d  = rand_buf();
    co_buf = d;
    found  = 1'b1;
    push_result(d);
    wait_pulse(50);
    tick(1);
    found = 1'b0;
    for (int i = 0; i < 200 && hs_count < h0 + 6; i++) @(negedge clk);
    check("mid_bytes", 32'(hs_count >= h0 + 6), 1);
    @(posedge clk);
    #1;
    res = 1'b1;
    exp_q.delete();
`ifdef RESULT_HEADER_EN
    seqn = 0;
`endif
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_pending", 32'(pending), 0);
    check("mid_rst_last", 32'(out_last), 0);
    tick(2);
    res = 1'b0;
    tick(30);
    check("post_rst_valid", 32'(out_valid), 0);
    check("post_rst_pending", 32'(pending), 0);

    // header sequence restarts from zero after reset
    ready_mode = 0;
    ready_val  = 1'b1;
    tick(1);
    issue(rand_buf());
    issue(rand_buf());
    drain(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
